formant_phi_engine: RTL
=======================

Name: formant_phi_engine

Overview:
- Per-frame formant angle-cosine engine, the parametrised successor to the fixed 5-formant phi stage; sits between the segment/T-value accumulator and the acos/frequency stage.
- Collects FORMANTS beats of cumulative T-values (3 lags each) and differences them into per-segment r0/r1/r2.
- Per segment: normalises, forms the cos estimate with one shared multiplier and a serial divider, saturates to signed Q1.(BIT_WIDTH-1).
- Unlike the free-running-counter predecessor, it is FSM-driven with ready/valid handshakes and deterministic latency.

Parameters:
BIT_WIDTH, 32, width of T-values and outputs (>= 16)
FORMANTS, 5, beats per frame and outputs per frame (>= 1)
MAX_SHIFT, 30, cap on normalisation left shift (<= BIT_WIDTH-2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
start_in  input  1  pulse: begin new frame (clears beat count)
t_vals_in  input  3*BIT_WIDTH  signed cumulative T(0),T(1),T(2) at right end of current segment
t_valid_in  input  1  beat valid
t_ready_out  output  1  high only in COLLECT
phi_out  output  FORMANTS*BIT_WIDTH  signed Q1.(BIT_WIDTH-1) cos estimate per formant, index 0 = first segment
phi_valid_out  output  1  frame result valid, held until accepted
phi_ready_in  input  1  downstream accept
busy_out  output  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock, clk_in; reset rst_in is synchronous, active-high. Reset returns to IDLE from any state, mid-frame included.
- Reset values: t_ready_out=0, phi_out=0, phi_valid_out=0, busy_out=0, beat count=0.
- States: IDLE, COLLECT, DIFF, NORM, MUL, SUB, MUL2, DIV, WRITE, HOLD.
- IDLE: start_in -> COLLECT.
- COLLECT:
  - Beat accepted on t_valid_in & t_ready_out and stored at index = count.
  - Accepting beat FORMANTS-1 -> DIFF with segment i=0.
  - start_in in COLLECT restarts the count at 0; same-cycle beat is discarded.
  - start_in in all other states is ignored.
- DIFF (1 cycle): r_k = T[k][0] for i=0, else T[k][i]-T[k][i-1]; BIT_WIDTH wrap arithmetic.
- NORM (1 cycle):
  - s = min over k of redundant sign bits of r_k, capped at MAX_SHIFT.
  - All r_k=0 gives s=0.
  - r_k <<= s.
- MUL (5 cycles, one product per cycle): m00, m11, m01, m12, m02, with m_xy = (r_x*r_y) >>> BIT_WIDTH, width BIT_WIDTH.
- SUB (1 cycle), all BIT_WIDTH+1 bits:
  - anum = m01-m12
  - omb = m00-m02
  - bnum = m11-m02
  - abd = m00-m11
- MUL2 (2 cycles), 2*BIT_WIDTH+2 bits:
  - num = (anum*omb) >>> 2
  - den = bnum*abd
- DIV (BIT_WIDTH-1 cycles, always full length): restoring serial divide, one quotient bit per cycle. Result:
  - den=0: 0 if num=0, else saturate by sign of num.
  - |num| >= |den|: +(2^(BIT_WIDTH-1)-1) if signs agree, else -2^(BIT_WIDTH-1).
  - Otherwise: floor(|num|*2^(BIT_WIDTH-1)/|den|), negated if signs differ.
- WRITE (1 cycle): phi_out[i] updated. If i<FORMANTS-1: i++, -> DIFF. Else -> HOLD.
- Per-segment latency is exactly BIT_WIDTH+10 cycles.
- HOLD: phi_valid_out=1 with phi_out stable. On phi_ready_in -> IDLE, phi_valid_out=0 next cycle.
- First phi_valid_out high: FORMANTS*(BIT_WIDTH+10) cycles after the cycle accepting the last beat.
- phi_out retains its last frame until the next WRITE overwrites it.

Optional Feature:
- Macro PHI_SAT_FLAG_EN.
- Defined: adds output sat_flags_out [FORMANTS]. Bit i is set in WRITE when segment i saturated or den=0; it is cleared on entry to DIFF for i=0 and on reset.
- Undefined: port absent, no flag logic; phi_out behaviour identical in both builds.

Test Plan:
- Sinusoid c=0.5: BIT_WIDTH=32, FORMANTS=2; beat0=(2^20, 2^19, -2^19), beat1=(2^21, 2^20, -2^20) -> phi_out[0]=phi_out[1]=0x40000000; phi_valid_out rises 84 cycles after beat1 accepted.
- c=0 segment: beat0 as above, beat1=(2^21, 2^19, -1572864) -> phi_out[0]=0x40000000, phi_out[1]=0x00000000.
- Saturation: single beat (2^21, 2^20, 0) -> 0x7FFFFFFF; all-zero beat -> 0x00000000; with PHI_SAT_FLAG_EN, both flags set.
- Backpressure and start handling: phi_ready_in held low 50 cycles -> phi_valid_out and phi_out stable throughout, t_ready_out=0, start_in ignored; accept -> IDLE.
- Mid-collect restart: start_in after 1 of 2 beats, then 2 fresh beats -> only the fresh beats are used, with the same results as scenario 1.
- Reset mid-DIV: rst_in for 1 cycle -> next cycle all outputs at reset values, busy_out=0; a following full frame produces the correct results.

Source files
------------

// File: rtl/formant_phi_engine.sv
// formant_phi_engine
//   Per-frame formant angle-cosine engine. Collects FORMANTS beats of
//   cumulative T-values (lags 0..2), differences them into per-segment
//   r0/r1/r2, normalises, builds the cos estimate with one shared multiplier
//   and a restoring serial divider, and saturates to signed Q1.(BIT_WIDTH-1).
//
// Ports
//   clk_in         system clock
//   rst_in         synchronous active-high reset
//   start_in       pulse: begin a new frame (restarts the beat count in COLLECT)
//   t_vals_in      {T(2), T(1), T(0)}: T(k) = t_vals_in[k*BIT_WIDTH +: BIT_WIDTH]
//   t_valid_in     beat valid
//   t_ready_out    beat ready, high only while collecting
//   phi_out        per-formant cos estimate, formant f at [f*BIT_WIDTH +: BIT_WIDTH]
//   phi_valid_out  frame result valid, held until accepted
//   phi_ready_in   downstream accept
//   busy_out       high whenever the engine is not idle
//   sat_flags_out  (only with PHI_SAT_FLAG_EN) per-segment saturation / den=0 flag
//
// Build option: define PHI_SAT_FLAG_EN to add sat_flags_out.
//
// state   | meaning
// IDLE    | waiting for start_in
// COLLECT | accepting FORMANTS beats of cumulative T-values
// DIFF    | difference cumulative T-values into r0..r2 for segment i
// NORM    | common left shift of r0..r2 by their minimum redundant sign bits
// MUL     | five products m00, m11, m01, m12, m02, one per cycle
// SUB     | anum, omb, bnum, abd
// MUL2    | num = (anum*omb)>>>2, then den = bnum*abd
// DIV     | BIT_WIDTH-1 cycles of restoring division on magnitudes
// WRITE   | saturate/sign the quotient into phi_out[i]; next segment or HOLD
// HOLD    | result presented until phi_ready_in

module formant_phi_engine #(
  parameter int BIT_WIDTH = 32,
  parameter int FORMANTS  = 5,
  parameter int MAX_SHIFT = 30
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic [3*BIT_WIDTH-1:0]        t_vals_in,
  input  logic                          t_valid_in,
  output logic                          t_ready_out,
  output logic [FORMANTS*BIT_WIDTH-1:0] phi_out,
  output logic                          phi_valid_out,
  input  logic                          phi_ready_in,
  output logic                          busy_out
`ifdef PHI_SAT_FLAG_EN
  ,
  output logic [FORMANTS-1:0]           sat_flags_out
`endif
);

  localparam int W  = BIT_WIDTH;
  localparam int PW = 2 * W + 2;
  localparam int IW = (FORMANTS > 1) ? $clog2(FORMANTS) : 1;
  localparam int CW = $clog2(W) + 1;
  localparam logic [IW-1:0] LAST = IW'(FORMANTS - 1);
  localparam logic [W-1:0]  MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MINV = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_COLLECT, S_DIFF, S_NORM, S_MUL, S_SUB, S_MUL2, S_DIV, S_WRITE, S_HOLD
  } state_t;

  state_t                state;
  logic [W-1:0]          tv [FORMANTS][3];
  logic [IW-1:0]         beat_cnt;
  logic [IW-1:0]         seg;
  logic [CW-1:0]         timer;
  logic signed [W-1:0]   r [3];
  logic signed [W-1:0]   m00, m11, m01, m12, m02;
  logic signed [W:0]     anum, omb, bnum, abd;
  logic signed [PW-1:0]  num, den;
  logic [PW-1:0]         rem;
  logic [W-2:0]          quo;
  logic [W-1:0]          phi [FORMANTS];

  // number of bits below the MSB that repeat the sign bit
  function automatic logic [CW-1:0] sign_run(input logic [W-1:0] v);
    logic [CW-1:0] n;
    logic          stop;
    n    = '0;
    stop = 1'b0;
    for (int b = W - 2; b >= 0; b--) begin
      if (!stop && (v[b] == v[W-1])) n = n + CW'(1);
      else stop = 1'b1;
    end
    return n;
  endfunction

  logic [CW-1:0] run0, run1, run2, run_min, shamt;

  always_comb begin
    run0    = sign_run(r[0]);
    run1    = sign_run(r[1]);
    run2    = sign_run(r[2]);
    run_min = run0;
    if (run1 < run_min) run_min = run1;
    if (run2 < run_min) run_min = run2;
    if ((r[0] == '0) && (r[1] == '0) && (r[2] == '0)) shamt = '0;
    else if (run_min > CW'(MAX_SHIFT))                   shamt = CW'(MAX_SHIFT);
    else                                                 shamt = run_min;
  end

  // Single (W+1)x(W+1) multiplier shared by MUL (sign-extended r operands)
  // and MUL2 (difference operands).
  logic signed [W:0]    mul_a, mul_b;
  logic signed [PW-1:0] prod;
  logic signed [W-1:0]  mhi;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state == S_MUL) begin
      case (timer)
        CW'(4):  begin mul_a = {r[0][W-1], r[0]}; mul_b = {r[0][W-1], r[0]}; end
        CW'(3):  begin mul_a = {r[1][W-1], r[1]}; mul_b = {r[1][W-1], r[1]}; end
        CW'(2):  begin mul_a = {r[0][W-1], r[0]}; mul_b = {r[1][W-1], r[1]}; end
        CW'(1):  begin mul_a = {r[1][W-1], r[1]}; mul_b = {r[2][W-1], r[2]}; end
        default: begin mul_a = {r[0][W-1], r[0]}; mul_b = {r[2][W-1], r[2]}; end
      endcase
    end else if (state == S_MUL2) begin
      if (timer == CW'(1)) begin mul_a = anum; mul_b = omb; end
      else                 begin mul_a = bnum; mul_b = abd; end
    end
  end

  assign prod = mul_a * mul_b;
  assign mhi  = W'(prod >>> W);

  logic [PW-1:0] num_mag, den_mag;
  logic [PW:0]   rem_dbl;
  logic          rem_ge;
  logic          signs_differ;
  logic [W-1:0]  res;

  assign num_mag      = num[PW-1] ? -$unsigned(num) : $unsigned(num);
  assign den_mag      = den[PW-1] ? -$unsigned(den) : $unsigned(den);
  assign rem_dbl      = {rem, 1'b0};
  assign rem_ge       = rem_dbl >= {1'b0, den_mag};
  assign signs_differ = num[PW-1] ^ den[PW-1];

  always_comb begin
    res = '0;
    if (den == '0) begin
      if (num != '0) res = num[PW-1] ? MINV : MAXV;
    end else if (num_mag >= den_mag) begin
      res = signs_differ ? MINV : MAXV;
    end else begin
      res = signs_differ ? -{1'b0, quo} : {1'b0, quo};
    end
  end

`ifdef PHI_SAT_FLAG_EN
  logic [FORMANTS-1:0] sat_flags;
  logic                seg_sat;
  assign seg_sat       = (den == '0) || (num_mag >= den_mag);
  assign sat_flags_out = sat_flags;
`endif

  for (genvar f = 0; f < FORMANTS; f++) begin : g_pack
    assign phi_out[f*W +: W] = phi[f];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= S_IDLE;
      t_ready_out   <= 1'b0;
      phi_valid_out <= 1'b0;
      busy_out      <= 1'b0;
      beat_cnt      <= '0;
      seg           <= '0;
      timer         <= '0;
      for (int f = 0; f < FORMANTS; f++) phi[f] <= '0;
`ifdef PHI_SAT_FLAG_EN
      sat_flags     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_in) begin
            state       <= S_COLLECT;
            t_ready_out <= 1'b1;
            busy_out    <= 1'b1;
            beat_cnt    <= '0;
          end
        end
        S_COLLECT: begin
          // a restart wins over a same-cycle beat, which is dropped
          if (start_in) begin
            beat_cnt <= '0;
          end else if (t_valid_in) begin
            for (int k = 0; k < 3; k++) tv[beat_cnt][k] <= t_vals_in[k*W +: W];
            if (beat_cnt == LAST) begin
              state       <= S_DIFF;
              t_ready_out <= 1'b0;
              beat_cnt    <= '0;
              seg         <= '0;
`ifdef PHI_SAT_FLAG_EN
              sat_flags   <= '0;
`endif
            end else begin
              beat_cnt <= beat_cnt + IW'(1);
            end
          end
        end
        S_DIFF: begin
          for (int k = 0; k < 3; k++) begin
            if (seg == '0) r[k] <= tv[0][k];
            else           r[k] <= tv[seg][k] - tv[seg - IW'(1)][k];
          end
          state <= S_NORM;
        end
        S_NORM: begin
          for (int k = 0; k < 3; k++) r[k] <= r[k] <<< shamt;
          timer <= CW'(4);
          state <= S_MUL;
        end
        S_MUL: begin
          case (timer)
            CW'(4):  m00 <= mhi;
            CW'(3):  m11 <= mhi;
            CW'(2):  m01 <= mhi;
            CW'(1):  m12 <= mhi;
            default: m02 <= mhi;
          endcase
          if (timer == '0) state <= S_SUB;
          else             timer <= timer - CW'(1);
        end
        S_SUB: begin
          anum  <= {m01[W-1], m01} - {m12[W-1], m12};
          omb   <= {m00[W-1], m00} - {m02[W-1], m02};
          bnum  <= {m11[W-1], m11} - {m02[W-1], m02};
          abd   <= {m00[W-1], m00} - {m11[W-1], m11};
          timer <= CW'(1);
          state <= S_MUL2;
        end
        S_MUL2: begin
          if (timer == CW'(1)) begin
            num   <= prod >>> 2;
            timer <= '0;
          end else begin
            // num is already registered, so the divider can be primed now
            den   <= prod;
            rem   <= num_mag;
            quo   <= '0;
            timer <= CW'(W - 2);
            state <= S_DIV;
          end
        end
        S_DIV: begin
          // always runs full length; the result is overridden in WRITE when
          // the quotient would not fit
          if (rem_ge) rem <= PW'(rem_dbl - {1'b0, den_mag});
          else        rem <= PW'(rem_dbl);
          quo <= {quo[W-3:0], rem_ge};
          if (timer == '0) state <= S_WRITE;
          else             timer <= timer - CW'(1);
        end
        S_WRITE: begin
          phi[seg] <= res;
`ifdef PHI_SAT_FLAG_EN
          sat_flags[seg] <= seg_sat;
`endif
          if (seg == LAST) begin
            state         <= S_HOLD;
            phi_valid_out <= 1'b1;
          end else begin
            seg   <= seg + IW'(1);
            state <= S_DIFF;
          end
        end
        S_HOLD: begin
          if (phi_ready_in) begin
            state         <= S_IDLE;
            phi_valid_out <= 1'b0;
            busy_out      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
